fb_pixel_reader: RTL and testbench

//  Read side of the double-buffered SRAM framebuffer: streams one frame of pixels, raster order, out of
//  the AXI-lite read channel into a ready/valid pixel stream with line/frame markers. Sits on the 100MHz
//  AXI clock between the SRAM arbiter and the display CDC FIFO; the pattern generator writes the other buffer.

---
 rtl/fb_pixel_reader_if.sv | 32 +++
 rtl/fb_pixel_reader.sv | 231 +++++++++++++++++++++++
 tb/tb_fb_pixel_reader.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_pixel_reader_if.sv
// Bundle of the AXI-lite read channel and the outgoing pixel stream of the framebuffer reader.
// The master modport is the reader side; slave is the SRAM arbiter / stream sink side.
interface fb_pixel_reader_if #(
   parameter int unsigned AXI_ADDR_WIDTH = 20,
   parameter int unsigned AXI_DATA_WIDTH = 16,
   parameter int unsigned PIXEL_BITS     = 12
);
   logic [AXI_ADDR_WIDTH-1:0] axi_araddr;
   logic                      axi_arvalid;
   logic                      axi_arready;
   logic [AXI_DATA_WIDTH-1:0] axi_rdata;
   logic [1:0]                axi_rresp;
   logic                      axi_rvalid;
   logic                      axi_rready;
   logic [PIXEL_BITS-1:0]     pixel_data;
   logic                      pixel_line_last;
   logic                      pixel_frame_last;
   logic                      pixel_valid;
   logic                      pixel_ready;

   modport master (
      output axi_araddr, axi_arvalid, axi_rready,
      output pixel_data, pixel_line_last, pixel_frame_last, pixel_valid,
      input  axi_arready, axi_rdata, axi_rresp, axi_rvalid, pixel_ready
   );

   modport slave (
      input  axi_araddr, axi_arvalid, axi_rready,
      input  pixel_data, pixel_line_last, pixel_frame_last, pixel_valid,
      output axi_arready, axi_rdata, axi_rresp, axi_rvalid, pixel_ready
   );
endinterface

// File: rtl/fb_pixel_reader.sv
// Streams one frame of the selected framebuffer, raster order, from the AXI-lite read channel
// into a ready/valid pixel stream with line/frame markers. Reads are credit-limited by the FIFO.
module fb_pixel_reader #(
   parameter int unsigned H_VISIBLE      = 640,
   parameter int unsigned V_VISIBLE      = 480,
   parameter int unsigned AXI_ADDR_WIDTH = 20,
   parameter int unsigned AXI_DATA_WIDTH = 16,
   parameter int unsigned PIXEL_BITS     = 12,
   parameter int unsigned FB0_BASE       = 0,
   parameter int unsigned FB1_BASE       = H_VISIBLE * V_VISIBLE,
   parameter int unsigned FIFO_DEPTH     = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              fb_sel,
   output logic              busy,
   output logic              frame_done,
   output logic              rd_err,
   fb_pixel_reader_if.master bus
);
   localparam int unsigned TOTAL = H_VISIBLE * V_VISIBLE;
   localparam int unsigned IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam int unsigned X_W   = (H_VISIBLE > 1) ? $clog2(H_VISIBLE) : 1;
   localparam int unsigned Y_W   = (V_VISIBLE > 1) ? $clog2(V_VISIBLE) : 1;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 2;

   localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(TOTAL - 1);
   localparam logic [X_W-1:0]            LAST_X   = X_W'(H_VISIBLE - 1);
   localparam logic [Y_W-1:0]            LAST_Y   = Y_W'(V_VISIBLE - 1);
   localparam logic [AXI_ADDR_WIDTH-1:0] BASE0    = AXI_ADDR_WIDTH'(FB0_BASE);
   localparam logic [AXI_ADDR_WIDTH-1:0] BASE1    = AXI_ADDR_WIDTH'(FB1_BASE);
   localparam logic [CNT_W-1:0]          DEPTH_C  = CNT_W'(FIFO_DEPTH);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StRun   = 2'd1;
   localparam logic [1:0] StDrain = 2'd2;

   logic [1:0]                state_q, state_d;
   logic                      fb_sel_q, fb_sel_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic                      arvalid_q, arvalid_d;
   logic [CNT_W-1:0]          in_flight_q, in_flight_d;
   logic                      rd_err_q, rd_err_d;
   logic                      frame_done_q, frame_done_d;
   logic [X_W-1:0]            out_x_q, out_x_d;
   logic [Y_W-1:0]            out_y_q, out_y_d;

   // Pixel FIFO: storage ring plus a registered head entry driving the stream.
   logic [PIXEL_BITS-1:0]     mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]          int_cnt_q, int_cnt_d;
   logic                      out_valid_q, out_valid_d;
   logic [PIXEL_BITS-1:0]     out_data_q, out_data_d;
   logic                      mem_we;
   logic                      int_pop;

   logic                      ar_hs;
   logic                      r_hs;
   logic                      pop;
   logic [PIXEL_BITS-1:0]     push_data;
   logic [CNT_W-1:0]          fifo_count;
   logic [CNT_W-1:0]          committed;
   logic                      issue_ok;
   logic                      line_last;
   logic                      frame_last;
   logic                      unused_rdata;

   assign ar_hs      = arvalid_q && bus.axi_arready;
   assign r_hs       = bus.axi_rvalid && (in_flight_q != '0);
   assign pop        = out_valid_q && bus.pixel_ready;
   assign push_data  = bus.axi_rdata[PIXEL_BITS-1:0];
   assign fifo_count = int_cnt_q + CNT_W'(out_valid_q);
   assign line_last  = (out_x_q == LAST_X);
   assign frame_last = line_last && (out_y_q == LAST_Y);

   // Every read owns a FIFO slot from arvalid until its pixel leaves; a pop frees one this cycle.
   assign committed  = in_flight_q + fifo_count + CNT_W'(arvalid_q) - CNT_W'(pop);
   assign issue_ok   = (committed < DEPTH_C);

   always_comb begin
      state_d      = state_q;
      fb_sel_d     = fb_sel_q;
      idx_d        = idx_q;
      araddr_d     = araddr_q;
      arvalid_d    = arvalid_q;
      rd_err_d     = rd_err_q;
      frame_done_d = 1'b0;
      out_x_d      = out_x_q;
      out_y_d      = out_y_q;
      in_flight_d  = in_flight_q + CNT_W'(ar_hs) - CNT_W'(r_hs);

      case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StRun;
               fb_sel_d  = fb_sel;
               idx_d     = '0;
               araddr_d  = fb_sel ? BASE1 : BASE0;
               arvalid_d = 1'b1;
               rd_err_d  = 1'b0;
               out_x_d   = '0;
               out_y_d   = '0;
            end
         end
         StRun: begin
            if (ar_hs) begin
               if (idx_q == LAST_IDX) begin
                  state_d   = StDrain;
                  arvalid_d = 1'b0;
               end else begin
                  idx_d     = idx_q + IDX_W'(1);
                  araddr_d  = araddr_q + AXI_ADDR_WIDTH'(1);
                  arvalid_d = issue_ok;
               end
            end else if (!arvalid_q) begin
               arvalid_d = issue_ok;
            end
         end
         StDrain: begin
            if (pop && frame_last) begin
               state_d      = StIdle;
               frame_done_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (r_hs && (bus.axi_rresp != 2'b00)) begin
         rd_err_d = 1'b1;
      end

      if (pop) begin
         if (line_last) begin
            out_x_d = '0;
            out_y_d = (out_y_q == LAST_Y) ? '0 : out_y_q + Y_W'(1);
         end else begin
            out_x_d = out_x_q + X_W'(1);
         end
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      rd_ptr_d    = rd_ptr_q;
      int_pop     = 1'b0;
      mem_we      = r_hs;
      if (!out_valid_q || pop) begin
         if (int_cnt_q != '0) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_q[rd_ptr_q];
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            int_pop     = 1'b1;
         end else if (r_hs) begin
            // Empty ring: the incoming beat goes straight to the head register.
            out_valid_d = 1'b1;
            out_data_d  = push_data;
            mem_we      = 1'b0;
         end else begin
            out_valid_d = 1'b0;
         end
      end
      wr_ptr_d  = mem_we ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      int_cnt_d = int_cnt_q + CNT_W'(mem_we) - CNT_W'(int_pop);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         fb_sel_q     <= 1'b0;
         idx_q        <= '0;
         araddr_q     <= '0;
         arvalid_q    <= 1'b0;
         in_flight_q  <= '0;
         rd_err_q     <= 1'b0;
         frame_done_q <= 1'b0;
         out_x_q      <= '0;
         out_y_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         int_cnt_q    <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         fb_sel_q     <= fb_sel_d;
         idx_q        <= idx_d;
         araddr_q     <= araddr_d;
         arvalid_q    <= arvalid_d;
         in_flight_q  <= in_flight_d;
         rd_err_q     <= rd_err_d;
         frame_done_q <= frame_done_d;
         out_x_q      <= out_x_d;
         out_y_q      <= out_y_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         int_cnt_q    <= int_cnt_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(bus.axi_rvalid && (in_flight_q == '0)))
            else $error("rvalid with no read outstanding");
      end
   end

   assign unused_rdata         = ^bus.axi_rdata;
   assign busy                 = (state_q != StIdle);
   assign frame_done           = frame_done_q;
   assign rd_err               = rd_err_q;
   assign bus.axi_araddr       = araddr_q;
   assign bus.axi_arvalid      = arvalid_q;
   assign bus.axi_rready       = 1'b1;
   assign bus.pixel_data       = out_data_q;
   assign bus.pixel_valid      = out_valid_q;
   assign bus.pixel_line_last  = out_valid_q && line_last;
   assign bus.pixel_frame_last = out_valid_q && frame_last;
endmodule

// File: tb/tb_fb_pixel_reader.sv
// Randomized bench for fb_pixel_reader: SRAM/arbiter responder plus a frame-level reference model
// checked against the DUT on every cycle.
module tb_fb_pixel_reader;
   localparam int H     = 4;
   localparam int V     = 2;
   localparam int TOTAL = H * V;
   localparam int DEPTH = 4;
   localparam int FB1   = 8;
   localparam int AW    = 20;
   localparam int DW    = 16;
   localparam int PW    = 12;

   logic clk    = 1'b0;
   logic reset  = 1'b1;
   logic start  = 1'b0;
   logic fb_sel = 1'b0;
   logic busy, frame_done, rd_err;

   fb_pixel_reader_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .PIXEL_BITS(PW)) bus ();

   fb_pixel_reader #(
      .H_VISIBLE(H), .V_VISIBLE(V), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
      .PIXEL_BITS(PW), .FB0_BASE(0), .FB1_BASE(FB1), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .fb_sel(fb_sel), .busy(busy),
      .frame_done(frame_done), .rd_err(rd_err), .bus(bus)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] sram [16];
   int  total = 0;
   int  bad = 0;
   int  exp_base = 0;
   int  ar_n = 0;
   int  pix_n = 0;
   int  lines_seen = 0;
   int  frames_seen = 0;
   int  done_cnt = 0;
   int  err_addr = -1;
   int  cyc = 0;
   bit  exp_busy = 1'b0;
   bit  exp_err = 1'b0;
   bit  rand_ar = 1'b0;
   bit  rand_lat = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // SRAM arbiter model: in-order responses after a 1..5 cycle latency.
   initial begin
      int q_addr[$];
      int q_due[$];
      bit ar_fire, r_fire;
      int fire_addr;
      bus.axi_arready = 1'b0;
      bus.axi_rvalid  = 1'b0;
      bus.axi_rdata   = '0;
      bus.axi_rresp   = 2'd0;
      forever begin
         @(negedge clk);
         ar_fire   = !reset && bus.axi_arvalid && bus.axi_arready;
         r_fire    = !reset && bus.axi_rvalid && bus.axi_rready;
         fire_addr = int'(bus.axi_araddr);
         @(posedge clk);
         #1;
         cyc++;
         if (reset) begin
            q_addr.delete();
            q_due.delete();
         end else begin
            if (r_fire && q_addr.size() > 0) begin
               void'(q_addr.pop_front());
               void'(q_due.pop_front());
            end
            if (ar_fire) begin
               q_addr.push_back(fire_addr);
               q_due.push_back(cyc + (rand_lat ? int'($urandom_range(1, 5)) : 1) - 1);
            end
         end
         bus.axi_arready = rand_ar ? 1'($urandom_range(0, 1)) : 1'b1;
         if (!reset && q_addr.size() > 0 && q_due[0] <= cyc) begin
            bus.axi_rvalid = 1'b1;
            bus.axi_rdata  = (q_addr[0] < 16) ? sram[q_addr[0]] : 16'hdead;
            bus.axi_rresp  = (q_addr[0] == err_addr) ? 2'd2 : 2'd0;
         end else begin
            bus.axi_rvalid = 1'b0;
            bus.axi_rdata  = 16'($urandom);
            bus.axi_rresp  = 2'd0;
         end
      end
   end

   // Compare process: frame-level model of addresses, stream contents, markers and status.
   initial begin
      bit ar_wait = 1'b0;
      bit px_wait = 1'b0;
      logic [AW-1:0] ar_prev;
      logic [PW-1:0] px_prev;
      logic ll_prev, fl_prev;
      forever begin
         @(negedge clk);
         if (reset) begin
            ar_wait = 1'b0;
            px_wait = 1'b0;
         end else begin
            if (exp_busy && pix_n == TOTAL) begin
               chk("frame_done_pulse", 32'(frame_done), 1);
               exp_busy = 1'b0;
               done_cnt++;
            end else begin
               chk("frame_done_quiet", 32'(frame_done), 0);
            end
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("rd_err", 32'(rd_err), 32'(exp_err));
            if (!exp_busy) begin
               chk("arvalid_idle", 32'(bus.axi_arvalid), 0);
               chk("pixel_valid_idle", 32'(bus.pixel_valid), 0);
            end
            if (ar_wait) begin
               chk("ar_hold_valid", 32'(bus.axi_arvalid), 1);
               chk("ar_hold_addr", 32'(bus.axi_araddr), 32'(ar_prev));
            end
            if (bus.axi_arvalid && bus.axi_arready) begin
               chk("araddr_order", 32'(bus.axi_araddr), 32'(exp_base + ar_n));
               ar_n++;
            end
            ar_wait = bus.axi_arvalid && !bus.axi_arready;
            ar_prev = bus.axi_araddr;
            if (px_wait) begin
               chk("px_hold_valid", 32'(bus.pixel_valid), 1);
               chk("px_hold_data", 32'(bus.pixel_data), 32'(px_prev));
               chk("px_hold_line", 32'(bus.pixel_line_last), 32'(ll_prev));
               chk("px_hold_frame", 32'(bus.pixel_frame_last), 32'(fl_prev));
            end
            if (bus.pixel_valid && bus.pixel_ready) begin
               chk("pixel_in_frame", 32'(pix_n < TOTAL), 1);
               if (pix_n < TOTAL) begin
                  chk("pixel_data", 32'(bus.pixel_data), 32'(sram[exp_base + pix_n][PW-1:0]));
                  chk("line_last", 32'(bus.pixel_line_last), 32'((pix_n % H) == H - 1));
                  chk("frame_last", 32'(bus.pixel_frame_last), 32'(pix_n == TOTAL - 1));
               end
               lines_seen  += int'(bus.pixel_line_last);
               frames_seen += int'(bus.pixel_frame_last);
               pix_n++;
            end
            px_wait = bus.pixel_valid && !bus.pixel_ready;
            px_prev = bus.pixel_data;
            ll_prev = bus.pixel_line_last;
            fl_prev = bus.pixel_frame_last;
            if (bus.axi_rvalid && bus.axi_rresp != 2'd0) exp_err = 1'b1;
            chk("outstanding_reads", 32'((ar_n - pix_n) <= DEPTH), 1);
         end
      end
   end

   task automatic do_start(input logic sel);
      fb_sel = sel;
      start  = 1'b1;
      tick();
      start       = 1'b0;
      exp_base    = sel ? FB1 : 0;
      ar_n        = 0;
      pix_n       = 0;
      lines_seen  = 0;
      frames_seen = 0;
      done_cnt    = 0;
      exp_err     = 1'b0;
      exp_busy    = 1'b1;
   endtask

   task automatic run_frame(input logic sel, input bit rnd, input int stall, input bit toggle,
                            input bit measure);
      int n;
      int lat;
      do_start(sel);
      chk("first_arvalid", 32'(bus.axi_arvalid), 1);
      chk("first_araddr", 32'(bus.axi_araddr), sel ? 32'(FB1) : 32'd0);
      if (measure) begin
         lat = 1;
         while (!bus.pixel_valid && lat < 20) begin
            tick();
            lat++;
         end
         chk("first_pixel_latency", 32'(lat), 3);
      end
      n = 0;
      while (exp_busy && n < 1000) begin
         bus.pixel_ready = (n < stall) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
         start = toggle && (n == 5);
         if (toggle) fb_sel = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      start           = 1'b0;
      fb_sel          = 1'b0;
      bus.pixel_ready = 1'b1;
      chk("frame_finished_in_budget", 32'(n < 1000), 1);
      chk("frame_done_count", 32'(done_cnt), 1);
      chk("line_last_count", 32'(lines_seen), V);
      chk("frame_last_count", 32'(frames_seen), 1);
      chk("busy_after_frame", 32'(busy), 0);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      chk("rst_rd_err", 32'(rd_err), 0);
      chk("rst_arvalid", 32'(bus.axi_arvalid), 0);
      chk("rst_araddr", 32'(bus.axi_araddr), 0);
      chk("rst_rready", 32'(bus.axi_rready), 1);
      chk("rst_pixel_valid", 32'(bus.pixel_valid), 0);
      chk("rst_pixel_data", 32'(bus.pixel_data), 0);
      chk("rst_line_last", 32'(bus.pixel_line_last), 0);
      chk("rst_frame_last", 32'(bus.pixel_frame_last), 0);
   endtask

   initial begin
      int n;
      for (int i = 0; i < 16; i++) sram[i] = 16'($urandom);
      bus.pixel_ready = 1'b1;
      tick();
      tick();
      #1;
      chk_reset_outputs();
      reset = 1'b0;
      tick();

      // Fixed timing, buffer 0, with first-pixel latency pinned.
      run_frame(1'b0, 1'b0, 0, 1'b0, 1'b1);
      // Buffer 1 with fb_sel wiggling and a stray start mid-frame.
      run_frame(1'b1, 1'b0, 0, 1'b1, 1'b0);
      // Sink stalled for 20 cycles.
      run_frame(1'b0, 1'b0, 20, 1'b0, 1'b0);

      rand_ar  = 1'b1;
      rand_lat = 1'b1;
      for (int f = 0; f < 4; f++) begin
         run_frame(1'($urandom_range(0, 1)), 1'b1, 0, 1'b1, 1'b0);
      end

      // Error response on pixel 5 only, sticky until the next start.
      err_addr = 5;
      run_frame(1'b0, 1'b1, 0, 1'b0, 1'b0);
      chk("rd_err_sticky", 32'(rd_err), 1);
      err_addr = -1;
      run_frame(1'b1, 1'b1, 0, 1'b0, 1'b0);
      chk("rd_err_cleared", 32'(rd_err), 0);

      // Reset after a few pixels, then a clean frame from index 0.
      rand_ar  = 1'b0;
      rand_lat = 1'b0;
      do_start(1'b0);
      n = 0;
      while (pix_n < 3 && n < 200) begin
         tick();
         n++;
      end
      chk("reached_three_pixels", 32'(n < 200), 1);
      reset = 1'b1;
      #1;
      chk_reset_outputs();
      exp_busy = 1'b0;
      exp_err  = 1'b0;
      pix_n    = 0;
      ar_n     = 0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      run_frame(1'b0, 1'b1, 0, 1'b0, 1'b0);
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end
endmodule
